// File: rtl/exec_profiler.sv
// rtl/exec_profiler.sv - windowed cycle/event profiler with shadow readout, threshold and overflow flags
module exec_profiler #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SEL_W    = 2,
  parameter int SATURATE = 1
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              in_clear,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic [NUM_CH-1:0] in_event,
  input  logic              in_snapshot,
  input  logic [CNT_W-1:0]  in_threshold,
  input  logic [SEL_W-1:0]  in_rd_sel,
  output logic              out_running,
  output logic              out_done,
  output logic [CNT_W-1:0]  out_cycle,
  output logic [CNT_W-1:0]  out_count,
  output logic [NUM_CH-1:0] out_over,
  output logic [NUM_CH:0]   out_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  live_cyc, shadow_cyc, cyc_next;
  logic [CNT_W-1:0]  live_ev   [NUM_CH];
  logic [CNT_W-1:0]  shadow_ev [NUM_CH];
  logic [CNT_W-1:0]  ev_next   [NUM_CH];
  logic              cyc_carry;
  logic [NUM_CH-1:0] ev_carry;
  logic [NUM_CH-1:0] over;
  logic [NUM_CH:0]   ovf;

  logic start_win, counting, capture;
  assign start_win = (state != RUN) && in_start;
  assign counting  = (state == RUN) && !in_stop;
  assign capture   = in_snapshot || ((state == RUN) && in_stop);

  always_ff @(posedge in_clk) begin
    if (in_reset || in_clear) state <= IDLE;
    else                      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (in_start) next_state = RUN;
      RUN:        if (in_stop)  next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    out_running = (state == RUN);
    out_done    = (state == DONE);
  end

  // Carry out of the increment marks overflow; result then saturates or wraps.
  always_comb begin
    logic [CNT_W:0] sum;
    sum       = {1'b0, live_cyc} + (CNT_W+1)'(1);
    cyc_carry = sum[CNT_W];
    cyc_next  = cyc_carry ? ((SATURATE != 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}}) : sum[CNT_W-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      sum         = {1'b0, live_ev[i]} + (CNT_W+1)'(1);
      ev_carry[i] = sum[CNT_W];
      ev_next[i]  = ev_carry[i] ? ((SATURATE != 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}}) : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset || in_clear) begin
      live_cyc   <= '0;
      shadow_cyc <= '0;
      over       <= '0;
      ovf        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        live_ev[i]   <= '0;
        shadow_ev[i] <= '0;
      end
    end else begin
      // Shadows take pre-increment values, so a stop edge captures the final window.
      if (capture) begin
        shadow_cyc <= live_cyc;
        for (int i = 0; i < NUM_CH; i++) shadow_ev[i] <= live_ev[i];
      end
      if (start_win) begin
        live_cyc <= '0;
        over     <= '0;
        ovf      <= '0;
        for (int i = 0; i < NUM_CH; i++) live_ev[i] <= '0;
      end else if (counting) begin
        live_cyc <= cyc_next;
        if (cyc_carry) ovf[NUM_CH] <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (in_event[i]) begin
            live_ev[i] <= ev_next[i];
            if (ev_carry[i]) ovf[i] <= 1'b1;
            if ((in_threshold != '0) && (ev_next[i] == in_threshold)) over[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    out_count = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (in_rd_sel == SEL_W'(i)) out_count = shadow_ev[i];
  end

  assign out_cycle = shadow_cyc;
  assign out_over  = over;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_exec_profiler.sv
// tb/tb_exec_profiler.sv - bench for exec_profiler: one 32-bit and two 8-bit (saturate/wrap) instances
module tb_exec_profiler;

  logic        clk = 1'b0;
  logic        rst, clr, start, stop, snap;
  logic [3:0]  ev;
  logic [31:0] thr;
  logic [2:0]  sel;

  always #5 clk = ~clk;

  logic        m_run, m_done, s_run, s_done, w_run, w_done;
  logic [31:0] m_cyc, m_cnt;
  logic [7:0]  s_cyc, s_cnt, w_cyc, w_cnt;
  logic [3:0]  m_over, s_over, w_over;
  logic [4:0]  m_ovf, s_ovf, w_ovf;

  exec_profiler #(.NUM_CH(4), .CNT_W(32), .SEL_W(3), .SATURATE(1)) u_main (
    .in_clk(clk), .in_reset(rst), .in_clear(clr), .in_start(start), .in_stop(stop),
    .in_event(ev), .in_snapshot(snap), .in_threshold(thr), .in_rd_sel(sel),
    .out_running(m_run), .out_done(m_done), .out_cycle(m_cyc), .out_count(m_cnt),
    .out_over(m_over), .out_ovf(m_ovf));

  exec_profiler #(.NUM_CH(4), .CNT_W(8), .SEL_W(3), .SATURATE(1)) u_sat (
    .in_clk(clk), .in_reset(rst), .in_clear(clr), .in_start(start), .in_stop(stop),
    .in_event(ev), .in_snapshot(snap), .in_threshold(thr[7:0]), .in_rd_sel(sel),
    .out_running(s_run), .out_done(s_done), .out_cycle(s_cyc), .out_count(s_cnt),
    .out_over(s_over), .out_ovf(s_ovf));

  exec_profiler #(.NUM_CH(4), .CNT_W(8), .SEL_W(3), .SATURATE(0)) u_wrap (
    .in_clk(clk), .in_reset(rst), .in_clear(clr), .in_start(start), .in_stop(stop),
    .in_event(ev), .in_snapshot(snap), .in_threshold(thr[7:0]), .in_rd_sel(sel),
    .out_running(w_run), .out_done(w_done), .out_cycle(w_cyc), .out_count(w_cnt),
    .out_over(w_over), .out_ovf(w_ovf));

  int checks = 0;
  int failures = 0;

  task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: unbounded window counts, mapped to each instance's width when observed.
  int          mstate = 0;
  bit          armed = 0;
  logic [63:0] n_cyc, sh_cyc;
  logic [63:0] n_ev [4];
  logic [63:0] sh_ev [4];
  logic [3:0]  ov [3];
  int          iw [3]   = '{32, 8, 8};
  bit          isat [3] = '{1, 1, 0};

  function automatic logic [63:0] maxv(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] mapv(input logic [63:0] n, input int w, input bit sat);
    if (n <= maxv(w)) return n;
    return sat ? maxv(w) : (n % (maxv(w) + 64'd1));
  endfunction

  task automatic cmp_inst(input int k, input string tag, input logic run, input logic done,
                          input logic [63:0] cyc, input logic [63:0] cnt,
                          input logic [3:0] over, input logic [4:0] ovf);
    logic [63:0] ecnt;
    logic [4:0]  eovf;
    ecnt = (sel < 3'd4) ? mapv(sh_ev[sel[1:0]], iw[k], isat[k]) : 64'd0;
    eovf = {n_cyc > maxv(iw[k]), n_ev[3] > maxv(iw[k]), n_ev[2] > maxv(iw[k]),
            n_ev[1] > maxv(iw[k]), n_ev[0] > maxv(iw[k])};
    checkv({tag, "_running"}, 64'(run), 64'(mstate == 1));
    checkv({tag, "_done"}, 64'(done), 64'(mstate == 2));
    checkv({tag, "_cycle"}, cyc, mapv(sh_cyc, iw[k], isat[k]));
    checkv({tag, "_count"}, cnt, ecnt);
    checkv({tag, "_over"}, 64'(over), 64'(ov[k]));
    checkv({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  always @(posedge clk) begin
    if (rst || clr) begin
      mstate = 0; n_cyc = 0; sh_cyc = 0; armed = 1;
      for (int i = 0; i < 4; i++) begin n_ev[i] = 0; sh_ev[i] = 0; end
      for (int k = 0; k < 3; k++) ov[k] = 0;
    end else begin
      if (snap || (mstate == 1 && stop)) begin
        sh_cyc = n_cyc;
        for (int i = 0; i < 4; i++) sh_ev[i] = n_ev[i];
      end
      if (mstate != 1 && start) begin
        mstate = 1; n_cyc = 0;
        for (int i = 0; i < 4; i++) n_ev[i] = 0;
        for (int k = 0; k < 3; k++) ov[k] = 0;
      end else if (mstate == 1 && stop) begin
        mstate = 2;
      end else if (mstate == 1) begin
        n_cyc++;
        for (int i = 0; i < 4; i++) if (ev[i]) begin
          n_ev[i]++;
          for (int k = 0; k < 3; k++) begin
            logic [63:0] t;
            t = 64'(thr) & maxv(iw[k]);
            if (t != 0 && mapv(n_ev[i], iw[k], isat[k]) == t) ov[k][i] = 1'b1;
          end
        end
      end
    end
    if (armed) begin
      #2;
      cmp_inst(0, "main", m_run, m_done, 64'(m_cyc), 64'(m_cnt), m_over, m_ovf);
      cmp_inst(1, "sat",  s_run, s_done, 64'(s_cyc), 64'(s_cnt), s_over, s_ovf);
      cmp_inst(2, "wrap", w_run, w_done, 64'(w_cyc), 64'(w_cnt), w_over, w_ovf);
    end
  end

  task automatic cyc(input bit st, input bit sp, input bit sn, input logic [3:0] e);
    start = st; stop = sp; snap = sn; ev = e;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; clr = 0; start = 0; stop = 0; snap = 0; ev = 0; thr = 0; sel = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    checkv("reset_running", 64'(m_run), 64'd0);
    checkv("reset_cycle", 64'(m_cyc), 64'd0);
    checkv("reset_ovf", 64'(s_ovf), 64'd0);

    // reset in the middle of a window, then a fresh window of N=4
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    checkv("midrun_running", 64'(m_run), 64'd1);
    rst = 1; cyc(0, 0, 0, 0); rst = 0;
    checkv("after_reset_running", 64'(m_run), 64'd0);
    checkv("after_reset_done", 64'(m_done), 64'd0);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    checkv("fresh_done", 64'(m_done), 64'd1);
    checkv("fresh_cycle", 64'(m_cyc), 64'd3);

    // start edge 0, event[1] on edges 2..6, stop edge 10
    sel = 1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 4'b0010);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    checkv("win_done", 64'(m_done), 64'd1);
    checkv("win_cycle", 64'(m_cyc), 64'd9);
    checkv("win_count", 64'(m_cnt), 64'd5);
    checkv("win_ovf", 64'(m_ovf), 64'd0);

    // 300 counted events on channel 0
    sel = 0;
    cyc(1, 0, 0, 0);
    repeat (300) cyc(0, 0, 0, 4'b0001);
    cyc(0, 1, 0, 0);
    checkv("sat_count", 64'(s_cnt), 64'd255);
    checkv("sat_cycle", 64'(s_cyc), 64'd255);
    checkv("sat_ovf", 64'(s_ovf), 64'b10001);
    checkv("wrap_count", 64'(w_cnt), 64'd44);
    checkv("wrap_cycle", 64'(w_cyc), 64'd44);
    checkv("wrap_ovf", 64'(w_ovf), 64'b10001);
    checkv("main_count300", 64'(m_cnt), 64'd300);

    // threshold on channel 2
    thr = 3; sel = 2;
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 4'b0100);
    checkv("thr_before", 64'(m_over), 64'd0);
    cyc(0, 0, 0, 4'b0100);
    checkv("thr_hit", 64'(m_over), 64'b0100);
    repeat (2) cyc(0, 0, 0, 4'b0100);
    cyc(0, 1, 0, 0);
    checkv("thr_sticky", 64'(m_over), 64'b0100);
    checkv("thr_count", 64'(m_cnt), 64'd5);
    thr = 0;
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 4'b0100);
    cyc(0, 1, 0, 0);
    checkv("thr_off", 64'(m_over), 64'd0);

    // snapshot while counting, then auto-capture on stop
    sel = 0;
    cyc(1, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 4'b0001);
    cyc(0, 0, 1, 4'b0001);
    checkv("snap_count", 64'(m_cnt), 64'd7);
    repeat (2) cyc(0, 0, 0, 4'b0001);
    cyc(0, 1, 0, 0);
    checkv("final_count", 64'(m_cnt), 64'd10);
    sel = 4; #1;
    checkv("sel_oob", 64'(m_cnt), 64'd0);

    // start+stop together, then clear+start together
    sel = 0;
    clr = 1; cyc(0, 0, 0, 0); clr = 0;
    cyc(1, 1, 0, 0);
    checkv("ss_idle_running", 64'(m_run), 64'd1);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checkv("ss_run_done", 64'(m_done), 64'd1);
    checkv("ss_run_cycle", 64'(m_cyc), 64'd2);
    clr = 1; cyc(1, 0, 0, 0); clr = 0;
    checkv("clr_running", 64'(m_run), 64'd0);
    checkv("clr_cycle", 64'(m_cyc), 64'd0);
    checkv("clr_done", 64'(m_done), 64'd0);

    repeat (2) cyc(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_profiler.md
Name: exec_profiler

Overview:
Multi-channel execution profiler. It extends the free-running execution cycle counter with a start/stop measurement window, per-channel event counters, snapshot readout, threshold flags and overflow handling. It sits beside the monitored core: the core drives event strobes, and the detection logic reads results through a channel-select mux.

Parameters:
NUM_CH, 4, number of event channels (1..16)
CNT_W, 32, width of the cycle counter and of each event counter (8..64)
SEL_W, 2, width of the channel-select port (must satisfy 2^SEL_W >= NUM_CH)
SATURATE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to zero

Ports:
in_clk  input  1  clock, all logic on rising edge
in_reset  input  1  synchronous, active-high reset
in_clear  input  1  synchronous soft clear, returns to IDLE
in_start  input  1  opens the measurement window
in_stop  input  1  closes the measurement window
in_event  input  NUM_CH  per-channel event strobe, one count per high cycle
in_snapshot  input  1  copies live counters into the shadow registers
in_threshold  input  CNT_W  compare value for the threshold flags; 0 disables them
in_rd_sel  input  SEL_W  selects which shadow event counter is driven on out_count
out_running  output  1  high while in RUN
out_done  output  1  high while in DONE
out_cycle  output  CNT_W  shadow copy of the cycle counter
out_count  output  CNT_W  shadow copy of the event counter for channel in_rd_sel
out_over  output  NUM_CH  sticky per-channel threshold-reached flags
out_ovf  output  NUM_CH+1  sticky overflow flags; bit NUM_CH belongs to the cycle counter

Behaviour:
- Priority at each edge: in_reset > in_clear > state-machine actions.
- in_reset or in_clear: state <= IDLE. All live counters, shadow registers, out_over and out_ovf <= 0. Every output reads 0 on the following cycle.
- State machine: IDLE, RUN, DONE.
  - IDLE/DONE with in_start=1 -> RUN. Live counters, out_over and out_ovf clear on that edge; shadow registers are kept. in_stop is ignored in IDLE/DONE.
  - RUN with in_stop=1 -> DONE. in_stop wins over a simultaneous in_start. in_start is ignored while in RUN.
- Counting: applies only on an edge where state==RUN and in_stop=0.
  - The cycle counter increments by 1 on each such edge.
  - Event counter i increments by 1 on each such edge where in_event[i]=1.
  - The edge that enters RUN does not count; the edge that leaves RUN does not count.
- Result: a window with start sampled at edge k and stop sampled at edge k+N yields cycle count N-1.
- Overflow, applied per counter when an increment would exceed all-ones:
  - SATURATE=1: the counter holds at all-ones.
  - SATURATE=0: the counter becomes 0.
  - Both modes: the matching out_ovf bit sets and stays set until the next start, clear or reset.
- Threshold: when in_threshold != 0 and an increment makes event counter i's new value equal to in_threshold, out_over[i] sets on that same edge. It is sticky until the next start, clear or reset. The comparison uses the post-increment, post-saturation value.
- Snapshot:
  - in_snapshot=1 in any state copies the current live register values (pre-increment on that edge) into the shadow registers.
  - The RUN->DONE edge also auto-captures the final live values; no in_snapshot is needed.
  - Shadow registers change only on snapshot, auto-capture, clear or reset.
- Readout: out_count is combinational from in_rd_sel over the shadow registers. A select value >= NUM_CH reads 0. out_cycle, out_running and out_done are driven directly from registers.
- Counter width: all arithmetic is CNT_W bits, unsigned; no sign extension.

Test Plan:
- Reset mid-RUN after 10 counted cycles -> next cycle all outputs 0 and state IDLE; a subsequent in_start begins a fresh window.
- in_start at edge 0, in_event[1]=1 on edges 2..6, in_stop at edge 10 -> out_done=1, out_cycle=9, in_rd_sel=1 gives out_count=5, out_ovf=0.
- CNT_W=8, SATURATE=1, in_event[0] held high for 300 counted cycles -> counter 255, out_ovf[0]=1 and out_ovf[NUM_CH]=1. Repeat with SATURATE=0 -> out_count=44, out_cycle=44, same ovf bits set.
- in_threshold=3, in_event[2] high for 5 counted cycles -> out_over[2] sets on the edge where count becomes 3 and stays set. in_threshold=0 -> out_over stays 0.
- in_snapshot on a RUN edge where in_event[0]=1 and the live count is 7 -> shadow holds 7. After a later stop, shadow holds the final value. in_rd_sel=NUM_CH reads 0.
- in_start and in_stop high together in IDLE -> enters RUN. Both high in RUN -> enters DONE. in_clear together with in_start -> IDLE, everything 0.
